// File: rtl/vec_mem_sequencer.sv
// Shares one single-port data RAM between a scalar port and a LANES-wide vector port,
// serialising vector accesses one lane per cycle. Define VEC_LANE_MASK_EN to add a per-lane skip mask.
module vec_mem_sequencer #(
  parameter int unsigned LANES   = 4,
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_req,
  input  logic             s_we,
  input  logic [AW-1:0]    s_addr,
  input  logic [DW-1:0]    s_wdata,
  output logic [DW-1:0]    s_rdata,
  output logic             s_done,
  input  logic             v_req,
  input  logic             v_we,
  input  logic [AW-1:0]    v_addr  [0:LANES-1],
  input  logic [DW-1:0]    v_wdata [0:LANES-1],
`ifdef VEC_LANE_MASK_EN
  input  logic [LANES-1:0] v_mask,
`endif
  output logic [DW-1:0]    v_rdata [0:LANES-1],
  output logic             v_done,
  output logic             stall,
  output logic             mem_en,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  input  logic [DW-1:0]    mem_rdata
);

  localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [2:0] {IDLE, SCALAR, VEC, WAIT, DONE} state_t;

  state_t             state, state_nx;
  logic               prio_vec, is_vec;
  logic               grant, grant_vec;
  logic [LANES-1:0]   grant_mask, mask_r;
  logic [LW-1:0]      lane_cnt, lane_nx, cur_lane;
  logic               any_lane, more_lanes, early_pend, issue_rd;
  logic [MEM_LAT-1:0] pend;
  logic [LW-1:0]      pend_lane [0:MEM_LAT-1];

  always_comb begin
`ifdef VEC_LANE_MASK_EN
    grant_mask = v_mask;
`else
    grant_mask = '1;
`endif
  end

  // current lane = first enabled lane at or after lane_cnt; more_lanes = another one follows it
  always_comb begin
    cur_lane   = lane_cnt;
    any_lane   = 1'b0;
    more_lanes = 1'b0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (i >= 32'(lane_cnt) && mask_r[i]) begin
        if (!any_lane) begin
          cur_lane = LW'(i);
          any_lane = 1'b1;
        end else begin
          more_lanes = 1'b1;
        end
      end
    end
  end

  always_comb begin
    early_pend = 1'b0;
    for (int unsigned i = 0; i + 1 < MEM_LAT; i++) begin
      early_pend = early_pend | pend[i];
    end
  end

  always_comb begin
    state_nx  = state;
    lane_nx   = lane_cnt;
    grant     = 1'b0;
    grant_vec = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    s_done    = 1'b0;
    v_done    = 1'b0;
    case (state)
      IDLE: begin
        if (s_req || v_req) begin
          grant     = 1'b1;
          grant_vec = v_req && (!s_req || prio_vec);
          state_nx  = grant_vec ? VEC : SCALAR;
          lane_nx   = '0;
        end
      end
      SCALAR: begin
        mem_en    = 1'b1;
        mem_we    = s_we;
        mem_addr  = s_addr;
        mem_wdata = s_wdata;
        state_nx  = s_we ? DONE : WAIT;
      end
      VEC: begin
        if (any_lane) begin
          mem_en    = 1'b1;
          mem_we    = v_we;
          mem_addr  = v_addr[cur_lane];
          mem_wdata = v_wdata[cur_lane];
          lane_nx   = cur_lane + LW'(1);
          if (!more_lanes) state_nx = v_we ? DONE : WAIT;
        end else begin
          state_nx = DONE;
        end
      end
      WAIT: begin
        if (!early_pend) state_nx = DONE;
      end
      DONE: begin
        s_done   = !is_vec;
        v_done   = is_vec;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // reset also blocks the access of the current cycle, so an interrupted write stops cleanly
    if (reset) begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      s_done    = 1'b0;
      v_done    = 1'b0;
    end
    issue_rd = mem_en && !mem_we;
    stall    = (s_req || v_req) && !(s_done || v_done);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      prio_vec <= 1'b0;
      is_vec   <= 1'b0;
      lane_cnt <= '0;
      mask_r   <= '0;
      pend     <= '0;
      s_rdata  <= '0;
      for (int unsigned i = 0; i < MEM_LAT; i++) pend_lane[i] <= '0;
      for (int unsigned i = 0; i < LANES; i++) v_rdata[i] <= '0;
    end else begin
      state    <= state_nx;
      lane_cnt <= lane_nx;
      if (grant) begin
        is_vec <= grant_vec;
        mask_r <= grant_mask;
        if (s_req && v_req) prio_vec <= !prio_vec;
        if (grant_vec && !v_we) begin
          for (int unsigned i = 0; i < LANES; i++) begin
            if (!grant_mask[i]) v_rdata[i] <= '0;
          end
        end
      end
      pend[0]      <= issue_rd;
      pend_lane[0] <= cur_lane;
      for (int unsigned i = 1; i < MEM_LAT; i++) begin
        pend[i]      <= pend[i-1];
        pend_lane[i] <= pend_lane[i-1];
      end
      if (pend[MEM_LAT-1]) begin
        if (is_vec) v_rdata[pend_lane[MEM_LAT-1]] <= mem_rdata;
        else        s_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: doc/vec_mem_sequencer.md
Name: vec_mem_sequencer

Overview:
- Shares a single-port data memory between the scalar memory port and the 4-lane vector memory port of the pipelined core.
- Serialises each vector access into one memory cycle per lane, collects vector read data into a lane buffer, and arbitrates between scalar and vector requests.
- Sits between the core's memory stage (scalar and vector address/data/write-enable) and the data RAM.
- Drives a stall to the core while any request is outstanding.

Parameters:
LANES, 4, number of vector lanes serialised per vector access
DW, 32, data width per lane
AW, 32, address width
MEM_LAT, 1, memory read latency in cycles from mem_en to valid mem_rdata (1..4)

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
s_req  input  1  scalar request; held high until s_done
s_we  input  1  scalar write (1) / read (0)
s_addr  input  AW  scalar address
s_wdata  input  DW  scalar write data
s_rdata  output  DW  scalar read data; valid while s_done=1
s_done  output  1  one-cycle completion pulse
v_req  input  1  vector request; held high until v_done
v_we  input  1  vector write / read
v_addr  input  LANES x AW  per-lane addresses, unpacked [0:LANES-1]
v_wdata  input  LANES x DW  per-lane write data, unpacked [0:LANES-1]
v_rdata  output  LANES x DW  per-lane read data, unpacked [0:LANES-1]; valid while v_done=1
v_done  output  1  one-cycle completion pulse
stall  output  1  core stall
mem_en  output  1  memory access strobe
mem_we  output  1  memory write enable
mem_addr  output  AW  memory address
mem_wdata  output  DW  memory write data
mem_rdata  input  DW  memory read data, MEM_LAT cycles after mem_en

Behaviour:
- Clock is clk. Reset is synchronous and active-high on reset. Reset wins over every other event.
- Reset values:
  - All outputs 0, including v_rdata lanes and s_rdata.
  - FSM in IDLE.
  - Priority pointer = scalar.
  - Lane counter 0; in-flight read tracking cleared.
- FSM states:
  - IDLE: sample s_req/v_req at the edge. Both high: grant the side indicated by the priority pointer, then toggle the pointer (alternating priority). One high: grant it; pointer unchanged. Go to SCALAR or VEC.
  - SCALAR: one cycle. mem_en=1, mem_we=s_we, mem_addr=s_addr, mem_wdata=s_wdata. Write goes to DONE; read goes to WAIT.
  - VEC: lane counter k = 0..LANES-1, one lane per cycle. mem_en=1, mem_we=v_we, mem_addr=v_addr[k], mem_wdata=v_wdata[k]. After lane LANES-1, a write goes to DONE and a read goes to WAIT.
  - WAIT: no new mem_en. mem_rdata is captured MEM_LAT cycles after each issue, into s_rdata or v_rdata[k] (pipelined per lane). Go to DONE the cycle after the final capture edge.
  - DONE: one cycle. Pulse s_done or v_done. Requests are ignored this cycle. Return to IDLE.
- Latency, request sampled high in cycle T0:
  - scalar write: done at T0+2
  - scalar read: done at T0+2+MEM_LAT
  - vector write: done at T0+1+LANES
  - vector read: done at T0+2+LANES+MEM_LAT-1 = T0+1+LANES+MEM_LAT
- Requester handshake:
  - Inputs must be held stable while req is high.
  - req must be deasserted in the cycle after done.
  - The arbiter does not sample in DONE, so no duplicate grant occurs.
- s_rdata/v_rdata hold their values until overwritten by the next read of the same port. Writes do not modify them.
- stall = (s_req | v_req) & ~(s_done | v_done). It is combinational from registered state and the req inputs.
- mem_en/mem_we are 0 in IDLE, WAIT and DONE.
- A request that drops mid-operation (protocol violation) does not abort: the transaction completes and the done pulse is issued.
- Reset asserted mid-operation: return to IDLE next edge. In-flight read data is discarded. No done pulse.

Optional Feature:
VEC_LANE_MASK_EN
- Defined:
  - Adds input v_mask [LANES-1:0], sampled at grant.
  - Masked-off lanes are skipped: no memory cycle, counter advances to the next enabled lane in the same cycle, and the v_rdata lane is forced to 0.
  - All-zero mask goes directly VEC to DONE, giving v_done at T0+2.
- Undefined: the port is absent and all LANES lanes are always accessed.

Test Plan:
- Scalar write s_addr=0x10, s_wdata=0xDEADBEEF at T0 (MEM_LAT=1) -> mem_en=mem_we=1, mem_addr=0x10 at T0+1; s_done at T0+2; stall high T0..T0+1.
- Scalar read of 0x10 after the previous write -> s_rdata=0xDEADBEEF with s_done at T0+3.
- Vector read with v_addr={0x20,0x24,0x28,0x2C}, memory preloaded {1,2,3,4} -> four consecutive mem_en cycles with ascending addresses; v_done at T0+6 with v_rdata={1,2,3,4}.
- s_req and v_req both rise at T0 after reset -> scalar served first. The vector transaction starts after s_done. Next simultaneous pair is served vector first.
- Reset asserted during lane 2 of a vector write -> only lanes 0-1 written; no v_done; all outputs 0 next cycle.
- With VEC_LANE_MASK_EN and v_mask=4'b0101 on a vector read -> only lanes 0 and 2 issued; v_rdata[1]=v_rdata[3]=0.
